// File: rtl/remainder_reg.sv
// rtl/remainder_reg.sv - remainder/quotient shift register for a restoring shift-subtract divider
module remainder_reg #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               SRL_ctrl,
    input  logic               SLL_ctrl,
    input  logic               W_ctrl,
    input  logic               Ready,
    input  logic               ALU_carry,
    input  logic [WIDTH-1:0]   ALU_result,
    input  logic [WIDTH-1:0]   Dividend_in,
    output logic [2*WIDTH-1:0] Remainder_out
);

    logic [2*WIDTH-1:0] r_q;
    logic [2*WIDTH-1:0] r_d;
    logic [WIDTH-1:0]   upper;
    logic               sub_ok;

    assign sub_ok = W_ctrl & ~ALU_carry;

    always_comb begin
        r_d   = r_q;
        upper = r_q[2*WIDTH-1:WIDTH];
        if (!Ready) begin
            if (SRL_ctrl) begin
                // Final correction undoes the last left shift of the remainder only.
                r_d[2*WIDTH-1:WIDTH] = r_q[2*WIDTH-1:WIDTH] >> 1;
            end else if (SLL_ctrl) begin
                if (sub_ok) begin
                    upper = ALU_result;
                end
                r_d    = {upper, r_q[WIDTH-1:0]} << 1;
                r_d[0] = sub_ok;
            end else if (sub_ok) begin
                r_d[2*WIDTH-1:WIDTH] = ALU_result;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_q <= {{(WIDTH-1){1'b0}}, Dividend_in, 1'b0};
        end else begin
            r_q <= r_d;
        end
    end

    assign Remainder_out = r_q;

endmodule

// File: tb/tb_remainder_reg.sv
// tb/tb_remainder_reg.sv - directed self-checking bench for remainder_reg
module tb_remainder_reg;

    logic        clk;
    logic        Reset;
    logic        SRL_ctrl;
    logic        SLL_ctrl;
    logic        W_ctrl;
    logic        Ready;
    logic        ALU_carry;
    logic [31:0] ALU_result;
    logic [31:0] Dividend_in;
    logic [63:0] Remainder_out;

    int total;
    int bad;

    remainder_reg #(.WIDTH(32)) dut (
        .clk          (clk),
        .Reset        (Reset),
        .SRL_ctrl     (SRL_ctrl),
        .SLL_ctrl     (SLL_ctrl),
        .W_ctrl       (W_ctrl),
        .Ready        (Ready),
        .ALU_carry    (ALU_carry),
        .ALU_result   (ALU_result),
        .Dividend_in  (Dividend_in),
        .Remainder_out(Remainder_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one set of controls, clock once, sample 1ns after the edge.
    task automatic cyc(input logic rst, input logic rdy, input logic srl, input logic sll,
                       input logic w, input logic carry, input logic [31:0] res,
                       input logic [31:0] div);
        Reset       = rst;
        Ready       = rdy;
        SRL_ctrl    = srl;
        SLL_ctrl    = sll;
        W_ctrl      = w;
        ALU_carry   = carry;
        ALU_result  = res;
        Dividend_in = div;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);

        //   rst rdy srl sll w  cy  ALU_result     Dividend_in
        cyc(1, 0, 0, 1, 1, 0, 32'hFF00_F0F0, 32'hFFFF_FFFF);
        check("reset_load", Remainder_out, 64'h0000_0001_FFFF_FFFE);
        cyc(0, 0, 0, 1, 0, 0, 32'hFF00_F0F0, 32'h0);
        check("plain_shift", Remainder_out, 64'h0000_0003_FFFF_FFFC);

        cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFF);
        check("reset_mid_op", Remainder_out, 64'h0000_0001_FFFF_FFFE);
        cyc(0, 0, 0, 1, 1, 0, 32'hFF00_F0F0, 32'h0);
        check("sub_ok_shift", Remainder_out, 64'hFE01_E1E1_FFFF_FFFD);
        cyc(0, 0, 1, 1, 1, 0, 32'h1234_5678, 32'h0);
        check("srl_priority", Remainder_out, 64'h7F00_F0F0_FFFF_FFFD);

        cyc(1, 0, 0, 0, 0, 0, 32'h0, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 1, 1, 1, 32'hFF00_F0F0, 32'h0);
        check("restore_shift", Remainder_out, 64'h0000_0003_FFFF_FFFC);

        cyc(0, 0, 0, 0, 1, 0, 32'h1234_5678, 32'h0);
        check("write_only_ok", Remainder_out, 64'h1234_5678_FFFF_FFFC);
        cyc(0, 0, 0, 0, 1, 1, 32'hAAAA_AAAA, 32'h0);
        check("write_only_borrow", Remainder_out, 64'h1234_5678_FFFF_FFFC);
        cyc(0, 0, 0, 0, 0, 0, 32'h5555_5555, 32'h0);
        check("idle_hold", Remainder_out, 64'h1234_5678_FFFF_FFFC);

        cyc(0, 1, 1, 1, 1, 0, 32'h0F0F_0F0F, 32'h0);
        check("freeze_1", Remainder_out, 64'h1234_5678_FFFF_FFFC);
        cyc(0, 1, 1, 1, 1, 1, 32'hDEAD_BEEF, 32'h0);
        check("freeze_2", Remainder_out, 64'h1234_5678_FFFF_FFFC);
        cyc(0, 1, 1, 1, 1, 0, 32'hCAFE_F00D, 32'h0);
        check("freeze_3", Remainder_out, 64'h1234_5678_FFFF_FFFC);
        cyc(1, 1, 1, 1, 1, 0, 32'hCAFE_F00D, 32'h8000_0001);
        check("reset_over_ready", Remainder_out, 64'h0000_0001_0000_0002);

        cyc(0, 0, 0, 0, 1, 0, 32'h8000_0000, 32'h0);
        check("load_msb", Remainder_out, 64'h8000_0000_0000_0002);
        cyc(0, 0, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'h0);
        check("sll_msb_dropped", Remainder_out, 64'h0000_0000_0000_0004);
        cyc(0, 0, 0, 0, 1, 0, 32'h0000_0001, 32'h0);
        check("load_lsb", Remainder_out, 64'h0000_0001_0000_0004);
        cyc(0, 0, 1, 0, 0, 0, 32'h0, 32'h0);
        check("srl_lsb_dropped", Remainder_out, 64'h0000_0000_0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/remainder_reg.md
Name: remainder_reg

Overview:
- 64-bit remainder/quotient shift register for a sequential shift-subtract (restoring) 32-bit divider.
- Upper half [63:32] holds the partial remainder. Lower half [31:0] holds the remaining dividend bits and the accumulating quotient bits.
- Sits between the divider controller (control strobes) and the 32-bit subtractor ALU (ALU_result, ALU_carry).

Parameters:
- WIDTH, 32, operand width. The register is 2*WIDTH bits. All examples below use WIDTH=32.

Ports:
- clk  input  1  rising-edge clock
- Reset  input  1  synchronous active-high reset; loads the dividend
- SRL_ctrl  input  1  logical shift right of upper half by 1 (final correction step)
- SLL_ctrl  input  1  shift whole register left by 1, with quotient bit insertion
- W_ctrl  input  1  write enable: take ALU_result into upper half when the subtraction succeeded
- Ready  input  1  division done; freeze register
- ALU_carry  input  1  subtractor borrow flag. 1 = remainder went negative (restore); 0 = subtraction succeeded.
- ALU_result  input  WIDTH  subtractor output (upper half minus divisor)
- Dividend_in  input  WIDTH  dividend, sampled on Reset
- Remainder_out  output  2*WIDTH  current register contents, driven directly from the register (no output logic delay)

Behaviour:
Single register R, updated only on the rising edge of clk. Priority per edge, highest first:
1. Reset=1: R <= {WIDTH'b0, Dividend_in} << 1, i.e. {31'b0, Dividend_in, 1'b0}. All other controls are ignored.
2. Ready=1: R holds.
3. SRL_ctrl=1: R[63:32] <= R[63:32] >> 1 (zero fill); R[31:0] holds. SLL_ctrl and W_ctrl are ignored.
4. SLL_ctrl=1:
   - Define U = (W_ctrl & ~ALU_carry) ? ALU_result : R[63:32].
   - Define q = W_ctrl ? ~ALU_carry : 1'b0.
   - R <= {U[30:0], R[31:0], q}. This is {U, R[31:0]} << 1 with q inserted at bit 0.
5. W_ctrl=1 only (no shift): R[63:32] <= ALU_carry ? R[63:32] : ALU_result; R[31:0] holds.
6. Otherwise: R holds.

Additional rules:
- No reset value other than via Reset. Initial contents before the first Reset are don't-care (X allowed in simulation).
- Reset asserted mid-division reloads the dividend immediately and abandons the current operation.
- Bit shifted out of R[63] on SLL is discarded. Bit shifted out of R[32] on SRL is discarded (it does not enter R[31]).
- Latency: every operation completes in one clock. There is no handshake; the controller guarantees sequencing.
- Purely combinational next-state logic feeding one 2*WIDTH flop bank.

Test Plan:
- Reset load: Reset=1, Dividend_in=32'hFFFF_FFFF, with SLL_ctrl=W_ctrl=1 also set -> after edge, Remainder_out=64'h0000_0001_FFFF_FFFE (Reset wins).
- Plain shift: from 64'h0000_0001_FFFF_FFFE, SLL=1, W=0 -> 64'h0000_0003_FFFF_FFFC.
- Successful subtract+shift: from 64'h0000_0001_FFFF_FFFE, SLL=1, W=1, ALU_carry=0, ALU_result=32'hFF00_F0F0 -> 64'hFE01_E1E1_FFFF_FFFD.
- Failed subtract (restore): same start, SLL=1, W=1, ALU_carry=1, ALU_result=32'hFF00_F0F0 -> 64'h0000_0003_FFFF_FFFC.
- Final correction: from 64'hFE01_E1E1_FFFF_FFFD, SRL=1 with SLL=1 -> 64'h7F00_F0F0_FFFF_FFFD.
- Freeze: Ready=1 with SLL=SRL=W=1 and changing ALU inputs for 3 cycles -> value unchanged. Then Reset=1 with Ready=1 -> dividend reload.
